// File: rtl/fofb_stream_demux.sv
// One-in, two-out byte stream demultiplexer steered by a header byte that is flagged by TUSER.
// Define FOFB_DEMUX_CNT_EN to add the per-port packet counters PKT_COUNT0/PKT_COUNT1.
module fofb_stream_demux #(
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             S00_AXIS_TVALID,
  output logic             S00_AXIS_TREADY,
  input  logic [7:0]       S00_AXIS_TDATA,
  input  logic             S00_AXIS_TUSER,
  output logic             M00_AXIS_TVALID,
  input  logic             M00_AXIS_TREADY,
  output logic [7:0]       M00_AXIS_TDATA,
  output logic             M00_AXIS_TUSER,
  output logic             M01_AXIS_TVALID,
  input  logic             M01_AXIS_TREADY,
  output logic [7:0]       M01_AXIS_TDATA,
  output logic             M01_AXIS_TUSER,
  output logic [CNT_W-1:0] DROP_COUNT
`ifdef FOFB_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] PKT_COUNT0,
  output logic [CNT_W-1:0] PKT_COUNT1
`endif
);

  typedef enum logic [2:0] {IDLE, ROUTE0, ROUTE1, BCAST, DROP} state_t;

  state_t state, next_state, hdr_state, target_state;
  logic   sop, free0, free1;
  logic   tgt0, tgt1, discard;
  logic   accept, load0, load1, drop_inc;

  assign sop   = S00_AXIS_TVALID & S00_AXIS_TUSER;
  assign free0 = ~M00_AXIS_TVALID | M00_AXIS_TREADY;
  assign free1 = ~M01_AXIS_TVALID | M01_AXIS_TREADY;

  // A header byte steers itself, so the decoded route applies in the same cycle it is presented.
  assign hdr_state    = S00_AXIS_TDATA[7] ? BCAST : (S00_AXIS_TDATA[0] ? ROUTE1 : ROUTE0);
  assign target_state = sop ? hdr_state : state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (accept) begin
      if (sop)                next_state = hdr_state;
      else if (state == IDLE) next_state = DROP;
    end
  end

  always_comb begin
    tgt0    = 1'b0;
    tgt1    = 1'b0;
    discard = 1'b0;
    case (target_state)
      ROUTE0:  tgt0 = 1'b1;
      ROUTE1:  tgt1 = 1'b1;
      BCAST: begin
        tgt0 = 1'b1;
        tgt1 = 1'b1;
      end
      default: discard = 1'b1;
    endcase
  end

  // Broadcast waits until both slots can take the byte, keeping the two outputs in lockstep.
  assign S00_AXIS_TREADY = ARESETN & (~tgt0 | free0) & (~tgt1 | free1);
  assign accept   = S00_AXIS_TVALID & S00_AXIS_TREADY;
  assign load0    = accept & tgt0;
  assign load1    = accept & tgt1;
  assign drop_inc = accept & discard;

  // A load takes priority over a drain, so a slot that is emptied and refilled in one cycle leaves no bubble.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      M00_AXIS_TVALID <= 1'b0;
      M00_AXIS_TDATA  <= '0;
      M00_AXIS_TUSER  <= 1'b0;
    end else if (load0) begin
      M00_AXIS_TVALID <= 1'b1;
      M00_AXIS_TDATA  <= S00_AXIS_TDATA;
      M00_AXIS_TUSER  <= S00_AXIS_TUSER;
    end else if (M00_AXIS_TREADY) begin
      M00_AXIS_TVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      M01_AXIS_TVALID <= 1'b0;
      M01_AXIS_TDATA  <= '0;
      M01_AXIS_TUSER  <= 1'b0;
    end else if (load1) begin
      M01_AXIS_TVALID <= 1'b1;
      M01_AXIS_TDATA  <= S00_AXIS_TDATA;
      M01_AXIS_TUSER  <= S00_AXIS_TUSER;
    end else if (M01_AXIS_TREADY) begin
      M01_AXIS_TVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                          DROP_COUNT <= '0;
    else if (drop_inc && DROP_COUNT != '1) DROP_COUNT <= DROP_COUNT + 1'b1;
  end

`ifdef FOFB_DEMUX_CNT_EN
  // Packet counters wrap rather than saturate.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      PKT_COUNT0 <= '0;
      PKT_COUNT1 <= '0;
    end else begin
      if (load0 && sop) PKT_COUNT0 <= PKT_COUNT0 + 1'b1;
      if (load1 && sop) PKT_COUNT1 <= PKT_COUNT1 + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fofb_stream_demux.md
FOFB_STREAM_DEMUX -- requirements
Module: fofb_stream_demux

Interface
REQ-001 Parameter: CNT_W, 16, width of the packet and drop counters.
REQ-002 Ports, one per line, in this order:
- ACLK  in  1  sole clock; all state changes on its rising edge.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- S00_AXIS_TVALID  in  1  input byte valid.
- S00_AXIS_TREADY  out  1  input byte accepted when high together with TVALID.
- S00_AXIS_TDATA  in  8  input byte.
- S00_AXIS_TUSER  in  1  start-of-packet (SOP) marker; the SOP byte is the header.
- M00_AXIS_TVALID / M01_AXIS_TVALID  out  1  output byte valid.
- M00_AXIS_TREADY / M01_AXIS_TREADY  in  1  sink ready.
- M00_AXIS_TDATA / M01_AXIS_TDATA  out  8  output byte.
- M00_AXIS_TUSER / M01_AXIS_TUSER  out  1  forwarded SOP marker.
- DROP_COUNT  out  CNT_W  bytes discarded with no SOP.
- PKT_COUNT0 / PKT_COUNT1  out  CNT_W  packets started on M00/M01; present only with FOFB_DEMUX_CNT_EN.

Function
REQ-003 The block splits one byte stream into two; each output register holds {TUSER, TDATA} and stays stable while TVALID=1 and TREADY=0.
REQ-004 Header decode on an SOP byte: bit7=1 selects BCAST; otherwise bit0 selects ROUTE0 (0) or ROUTE1 (1).
REQ-005 FSM states: IDLE, ROUTE0, ROUTE1, BCAST, DROP; reset state is IDLE.
REQ-006 Transitions:
- Any state, on an accepted SOP byte: go to the decoded state.
- IDLE, on an accepted non-SOP byte: go to DROP.
- ROUTE/BCAST, on non-SOP bytes: hold state.
- DROP, on non-SOP bytes: hold state.
REQ-007 The SOP byte itself is forwarded, with TUSER=1, to the port(s) it selects.
REQ-008 Latency is exactly one cycle: a byte accepted at edge N is presented on the selected M port(s) from edge N+1.
REQ-009 An output slot is free when its TVALID=0 or its TREADY=1.
REQ-010 S00_AXIS_TREADY values:
- SOP byte present: the decoded target slot(s) are free.
- ROUTEx: Mx slot is free.
- BCAST: both slots are free.
- IDLE with a non-SOP byte present, and DROP: 1.
REQ-011 S00_AXIS_TREADY may depend combinationally on M TREADY; no combinational path exists from S00_AXIS_TVALID to any M TVALID.
REQ-012 In BCAST a byte is accepted only when it can load both outputs in the same cycle; the outputs never diverge by more than one byte.
REQ-013 Simultaneous drain and load on one port in one cycle sustains one byte per cycle with no bubble.
REQ-014 DROP_COUNT increments once per byte discarded in IDLE or DROP and saturates at all-ones.
REQ-015 A port whose TREADY stays low stalls the input indefinitely while it is targeted; there is no timeout and no data loss.

Reset
REQ-016 While ARESETN=0:
- All M TVALID, M TDATA and M TUSER are 0.
- S00_AXIS_TREADY is 0.
- State is IDLE.
- All counters are 0.
REQ-017 A reset asserted mid-packet discards held output bytes immediately; after release, non-SOP bytes are dropped until the next SOP.

Configuration
REQ-018 Macro FOFB_DEMUX_CNT_EN:
- Defined: PKT_COUNT0/1 exist; each increments when an SOP byte loads its port (both ports for BCAST); they wrap modulo 2^CNT_W.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Verification
REQ-019 Routed packet: header 0x00 then 0x11, 0x22, both sinks ready -> M00 outputs {1,0x00},{0,0x11},{0,0x22} on consecutive cycles one cycle after input; M01_AXIS_TVALID stays 0.
REQ-020 Broadcast with stall: header 0x80 then 0x55, M01_AXIS_TREADY low 3 cycles -> S00_AXIS_TREADY low for those cycles; both ports emit identical {1,0x80},{0,0x55}; no loss or duplication.
REQ-021 Orphan bytes: 4 non-SOP bytes after reset, then header 0x01 and 0x33 -> DROP_COUNT=4; M01 outputs {1,0x01},{0,0x33}; M00 is silent.
REQ-022 Back-to-back switch: packet to M00 immediately followed by SOP 0x01, sinks always ready -> full throughput with no bubble; the second header appears only on M01; PKT_COUNT0=1 and PKT_COUNT1=1 with the macro defined.
REQ-023 Reset mid-packet: ARESETN pulsed low while M00 holds a byte with TREADY=0 -> M00_AXIS_TVALID is 0 asynchronously, counters are 0, and the following non-SOP bytes increment DROP_COUNT.
REQ-024 Counter wrap (CNT_W=4, macro defined): 17 single-byte packets to M01 -> PKT_COUNT1=1; 20 orphan bytes -> DROP_COUNT=15.
